// File: rtl/poly_stream_io_pkg.sv
// Shared constants, FSM encoding and operand-slot addressing for the
// polynomial stream front/back end.
package poly_stream_io_pkg;

  localparam int N     = 17;
  localparam int D     = 16;
  localparam int Q     = 65537;
  localparam int LAT   = 32;
  localparam int CNT_W = $clog2(2*D+1);
  localparam int RUN_W = $clog2(LAT+1);
  localparam int OUT_W = $clog2(D);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_UNLOAD  = 3'd4
  } state_t;

  // Bit offset of input beat 'slot' in the flat operand bus: A occupies the upper half.
  function automatic int slot_lsb(input logic [CNT_W-1:0] slot);
    if (int'(slot) < D) begin
      return N*D + N*int'(slot);
    end else begin
      return N*(int'(slot) - D);
    end
  endfunction

endpackage

// File: rtl/poly_serializer.sv
// Holds the captured product and streams it out one coefficient per
// valid/ready handshake, flagging the final coefficient with m_last.
module poly_serializer
  import poly_stream_io_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [N*D-1:0]   c_i,
  input  logic             m_ready_i,
  output logic             m_valid_o,
  output logic [N-1:0]     m_data_o,
  output logic             m_last_o,
  output logic             done_o
);

  logic [N*D-1:0] prod_q, prod_d;
  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
  logic           m_valid_q, m_valid_d;
  logic [N-1:0]   m_data_q, m_data_d;
  logic           m_last_q, m_last_d;
  logic           hs_s;

  assign hs_s   = m_valid_q & m_ready_i;
  assign done_o = hs_s & m_last_q;

  // Next-state: load a fresh product, advance on handshake, hold otherwise.
  always_comb begin
    prod_d    = prod_q;
    out_cnt_d = out_cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (load_i) begin
      prod_d    = c_i;
      out_cnt_d = '0;
      m_valid_d = 1'b1;
      m_data_d  = c_i[N-1:0];
      m_last_d  = 1'b0;
    end else if (hs_s) begin
      if (m_last_q) begin
        out_cnt_d = '0;
        m_valid_d = 1'b0;
        m_data_d  = '0;
        m_last_d  = 1'b0;
      end else begin
        out_cnt_d = out_cnt_q + OUT_W'(1);
        m_data_d  = prod_q[N*(int'(out_cnt_q)+1) +: N];
        m_last_d  = (out_cnt_q == OUT_W'(D-2));
      end
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // Output and product registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q    <= '0;
      out_cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      out_cnt_q <= out_cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;

endmodule

// File: rtl/poly_stream_io.sv
// Stream wrapper around the flat NTT multiplier: deserialise A and B, run the
// core for LAT enabled cycles, capture the product and stream it back out.
module poly_stream_io
  import poly_stream_io_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [N-1:0]       s_data,
  output logic [2*N*D-1:0]   core_a,
  output logic               core_run,
  input  logic [N*D-1:0]     core_c,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [N-1:0]       m_data,
  output logic               m_last,
  output logic               busy,
  output logic               err_range
);

  localparam logic [N-1:0] Q_C = N'(Q);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [2*N*D-1:0]   core_a_q, core_a_d;
  logic               err_q, err_d;
  logic               s_ready_q, core_run_q, busy_q;
  logic               s_fire_s, over_s, capture_s, done_s;

  assign s_fire_s = s_valid & s_ready_q;
  assign over_s   = (s_data >= Q_C);

  // FSM next state, operand deserialiser and range flag.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    run_cnt_d = run_cnt_q;
    core_a_d  = core_a_q;
    err_d     = err_q;
    capture_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (s_fire_s) begin
          core_a_d[slot_lsb(CNT_W'(0)) +: N] = s_data;
          in_cnt_d = CNT_W'(1);
          err_d    = over_s;
          state_d  = S_LOAD;
        end else begin
          in_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (s_fire_s) begin
          core_a_d[slot_lsb(in_cnt_q) +: N] = s_data;
          in_cnt_d = in_cnt_q + CNT_W'(1);
          err_d    = err_q | over_s;
          if (in_cnt_q == CNT_W'(2*D-1)) begin
            run_cnt_d = '0;
            state_d   = S_RUN;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + RUN_W'(1);
        if (run_cnt_q == RUN_W'(LAT-1)) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_CAPTURE: begin
        capture_s = 1'b1;
        state_d   = S_UNLOAD;
      end
      S_UNLOAD: begin
        if (done_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_UNLOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, operands; handshake outputs are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      in_cnt_q   <= '0;
      run_cnt_q  <= '0;
      core_a_q   <= '0;
      err_q      <= 1'b0;
      s_ready_q  <= 1'b1;
      core_run_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      run_cnt_q  <= run_cnt_d;
      core_a_q   <= core_a_d;
      err_q      <= err_d;
      s_ready_q  <= (state_d == S_IDLE) || (state_d == S_LOAD);
      core_run_q <= (state_d == S_RUN);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  poly_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load_i    (capture_s),
    .c_i       (core_c),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .done_o    (done_s)
  );

  assign s_ready   = s_ready_q;
  assign core_a    = core_a_q;
  assign core_run  = core_run_q;
  assign busy      = busy_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_poly_stream_io.sv
// Directed bench for poly_stream_io with a behavioural core stub that
// produces its result only on the LAT-th enabled cycle.
module tb_poly_stream_io;
  import poly_stream_io_pkg::*;

  typedef logic [N-1:0] vec_t [D];

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid, s_ready;
  logic [N-1:0]     s_data;
  logic [2*N*D-1:0] core_a;
  logic             core_run;
  logic [N*D-1:0]   core_c;
  logic             m_valid, m_ready, m_last, busy, err_range;
  logic [N-1:0]     m_data;

  int checks = 0, errors = 0;
  int cyc = 0, run_hi = 0, en_cnt = 0;
  int hs_first, hs_last, mv_first, mlast_hs, r0;
  bit stub_mul = 1'b0;
  vec_t a_v, b_v, c_v, a2, b2, c2;

  poly_stream_io dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .core_a(core_a), .core_run(core_run), .core_c(core_c), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy), .err_range(err_range)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (core_run) run_hi <= run_hi + 1;

  // Negacyclic product mod Q: c = a*b mod (x^D + 1).
  function automatic logic [N*D-1:0] nc_mul(input logic [2*N*D-1:0] ab);
    longint acc [D];
    logic [N*D-1:0] r;
    for (int k = 0; k < D; k++) acc[k] = 0;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        longint p = longint'(ab[N*D+N*i +: N]) * longint'(ab[N*j +: N]);
        if (i + j < D) acc[i+j] += p;
        else acc[i+j-D] -= p;
      end
    for (int k = 0; k < D; k++) r[N*k +: N] = N'(((acc[k] % Q) + Q) % Q);
    return r;
  endfunction

  // Core stub: result appears only on the LAT-th enabled edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      en_cnt <= 0;
      core_c <= '0;
    end else if (core_run) begin
      if (en_cnt == LAT-1) begin
        en_cnt <= 0;
        core_c <= stub_mul ? nc_mul(core_a) : core_a[2*N*D-1:N*D];
      end else begin
        en_cnt <= en_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input vec_t av, input vec_t bv, input bit gaps, input bit hold, input int nb);
    logic fire;
    int   tmo;
    bit   any_over = 1'b0;
    for (int k = 0; k < nb; k++) begin
      logic [N-1:0] v = (k < D) ? av[k] : bv[k-D];
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      s_valid = 1'b1;
      s_data  = v;
      fire = 1'b0;
      tmo  = 0;
      while (!fire && tmo < 100) begin
        fire = s_ready;
        step();
        tmo++;
      end
      if (!fire) chk("s_accept_timeout", 64'd0, 64'd1);
      any_over |= (v >= Q);
      if (k == 0) begin
        hs_first = cyc;
        chk("err_after_beat0", err_range, v >= Q);
      end
    end
    if (!hold) s_valid = 1'b0;
    hs_last = cyc;
    if (nb == 2*D) chk("err_after_load", err_range, any_over);
  endtask

  task automatic recv_job(input vec_t ev, input int stall_k, input bit exp_err, input bit chk_sready);
    int tmo;
    m_ready = 1'b1;
    for (int k = 0; k < D; k++) begin
      tmo = 0;
      while (!m_valid && tmo < 200) begin
        if (chk_sready) chk("s_ready_low_run", s_ready, 1'b0);
        step();
        tmo++;
      end
      if (!m_valid) chk("m_valid_timeout", 64'd0, 64'd1);
      if (k == 0) mv_first = cyc;
      chk($sformatf("c[%0d]", k), m_data, ev[k]);
      chk($sformatf("m_last[%0d]", k), m_last, k == D-1);
      chk("err_unload", err_range, exp_err);
      if (chk_sready) chk("s_ready_low_unload", s_ready, 1'b0);
      if (k == stall_k) begin
        m_ready = 1'b0;
        repeat (3) begin
          step();
          chk("stall_data", m_data, ev[k]);
          chk("stall_valid", m_valid, 1'b1);
        end
        m_ready = 1'b1;
      end
      step();
    end
    mlast_hs = cyc;
    chk("m_valid_after_last", m_valid, 1'b0);
    chk("busy_after_last", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) step();
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_core_run", core_run, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", err_range, 1'b0);
    chk("rst_core_a_zero", |core_a, 1'b0);
    rst = 1'b0;
    step();

    // Reset during LOAD after five beats.
    for (int i = 0; i < D; i++) begin a_v[i] = N'(i+1); b_v[i] = '0; c_v[i] = N'(i+1); end
    send_job(a_v, b_v, 1'b0, 1'b0, 5);
    chk("load_busy", busy, 1'b1);
    chk("load_a4", core_a[N*D+N*4 +: N], 5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_s_ready", s_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_core_a_zero", |core_a, 1'b0);
    chk("midrst_m_valid", m_valid, 1'b0);
    step();
    rst = 1'b0;
    step();

    // A=1..16, B=0 through the pass-through stub; latency and enable count.
    send_job(a_v, b_v, 1'b0, 1'b0, 2*D);
    r0 = run_hi;
    recv_job(c_v, -1, 1'b0, 1'b1);
    // Counted in edges: m_valid rises LAT+1 edges after the accepting edge (cycle t+LAT+2).
    chk("latency", mv_first - hs_last, LAT+1);
    chk("core_run_cycles", run_hi - r0, LAT);

    // Input gaps and a 3-cycle output stall on beat 7.
    for (int i = 0; i < D; i++) begin a_v[i] = N'(1000 + 7*i); c_v[i] = N'(1000 + 7*i); end
    send_job(a_v, b_v, 1'b1, 1'b0, 2*D);
    recv_job(c_v, 7, 1'b0, 1'b0);

    // Out-of-range beat 4 is stored unmodified and flagged.
    for (int i = 0; i < D; i++) begin a_v[i] = N'(i+1); c_v[i] = N'(i+1); end
    a_v[4] = N'(65537); c_v[4] = N'(65537);
    send_job(a_v, b_v, 1'b0, 1'b0, 2*D);
    recv_job(c_v, -1, 1'b1, 1'b0);

    // Back-to-back negacyclic jobs with s_valid held high.
    stub_mul = 1'b1;
    for (int i = 0; i < D; i++) begin
      a_v[i] = '0; b_v[i] = N'(i+1); c_v[i] = N'(i+1);
      a2[i] = '0;  b2[i] = '0;       c2[i] = '0;
    end
    a_v[0] = N'(1); a2[0] = N'(2); b2[0] = N'(3); c2[0] = N'(6);
    send_job(a_v, b_v, 1'b0, 1'b1, 2*D);
    recv_job(c_v, -1, 1'b0, 1'b1);
    send_job(a2, b2, 1'b0, 1'b0, 2*D);
    chk("b2b_first_accept", hs_first - mlast_hs, 1);
    recv_job(c2, -1, 1'b0, 1'b1);

    // Reset during UNLOAD drops m_valid at once.
    send_job(a2, b2, 1'b0, 1'b0, 2*D);
    m_ready = 1'b0;
    begin
      int tmo = 0;
      while (!m_valid && tmo < 200) begin step(); tmo++; end
    end
    chk("unload_reached", m_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("unload_rst_m_valid", m_valid, 1'b0);
    chk("unload_rst_busy", busy, 1'b0);
    step();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
